// File: rtl/narrow_link_responder.sv
// Responder on a narrow 4-phase bundled-data link: assembles a request from
// BW_LINK-wide chunks, hands it to a local consumer, then returns the response chunk by chunk.
module narrow_link_responder #(
  parameter int unsigned BW_LINK = 3,
  parameter int unsigned BW_REQ  = 4,
  parameter int unsigned BW_RSP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_req,
  input  logic [BW_LINK-1:0] rx_data,
  output logic               rx_ack,
  output logic               tx_req,
  output logic [BW_LINK-1:0] tx_data,
  input  logic               tx_ack,
  output logic               req_valid,
  output logic [BW_REQ-1:0]  req_data,
  input  logic               req_ready,
  input  logic               rsp_valid,
  input  logic [BW_RSP-1:0]  rsp_data,
  output logic               rsp_ready
);

  localparam int unsigned NQ   = (BW_REQ + BW_LINK - 1) / BW_LINK;
  localparam int unsigned NR   = (BW_RSP + BW_LINK - 1) / BW_LINK;
  localparam int unsigned NMAX = (NQ > NR) ? NQ : NR;
  localparam int unsigned CW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int unsigned RXW  = NQ * BW_LINK;
  localparam int unsigned TXW  = NR * BW_LINK;

  typedef enum logic [2:0] {
    RX_WAIT,
    RX_REL,
    DELIVER,
    RSP_WAIT,
    TX_DRIVE,
    TX_REL
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      rx_sync;
  logic [1:0]      tx_sync;
  logic            rx_req_s;
  logic            tx_ack_s;
  logic [RXW-1:0]  rx_shift;
  logic [TXW-1:0]  tx_shift;
  logic [RXW-1:0]  rx_next;
  logic [TXW-1:0]  tx_next;
  logic [TXW-1:0]  tx_load;

  assign rx_req_s = rx_sync[1];
  assign tx_ack_s = tx_sync[1];

  // New chunk enters at the MSB end so the first chunk ends up least significant
  assign rx_next  = RXW'({rx_data, rx_shift} >> BW_LINK);
  assign tx_next  = tx_shift >> BW_LINK;
  assign tx_load  = TXW'(rsp_data);
  assign req_data = rx_shift[BW_REQ-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_WAIT;
      cnt       <= '0;
      rx_sync   <= '0;
      tx_sync   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_ack    <= 1'b0;
      tx_req    <= 1'b0;
      tx_data   <= '0;
      req_valid <= 1'b0;
      rsp_ready <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx_req};
      tx_sync <= {tx_sync[0], tx_ack};
      case (state)
        RX_WAIT: begin
          if (rx_req_s) begin
            rx_shift <= rx_next;
            rx_ack   <= 1'b1;
            state    <= RX_REL;
          end
        end
        RX_REL: begin
          if (!rx_req_s) begin
            rx_ack <= 1'b0;
            if (cnt == CW'(NQ - 1)) begin
              cnt       <= '0;
              req_valid <= 1'b1;
              state     <= DELIVER;
            end else begin
              cnt   <= cnt + CW'(1);
              state <= RX_WAIT;
            end
          end
        end
        DELIVER: begin
          if (req_valid && req_ready) begin
            req_valid <= 1'b0;
            rsp_ready <= 1'b1;
            state     <= RSP_WAIT;
          end
        end
        RSP_WAIT: begin
          if (rsp_valid) begin
            tx_shift  <= tx_load;
            tx_data   <= tx_load[BW_LINK-1:0];
            rsp_ready <= 1'b0;
            state     <= TX_DRIVE;
          end
        end
        TX_DRIVE: begin
          // tx_req rises one clock after tx_data was loaded
          if (!tx_req) begin
            tx_req <= 1'b1;
          end else if (tx_ack_s) begin
            tx_req <= 1'b0;
            state  <= TX_REL;
          end
        end
        TX_REL: begin
          if (!tx_ack_s) begin
            if (cnt == CW'(NR - 1)) begin
              cnt   <= '0;
              state <= RX_WAIT;
            end else begin
              tx_shift <= tx_next;
              tx_data  <= tx_next[BW_LINK-1:0];
              cnt      <= cnt + CW'(1);
              state    <= TX_DRIVE;
            end
          end
        end
        default: state <= RX_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_narrow_link_responder.sv
// Bench acting as link master and local consumer/producer for narrow_link_responder,
// with expected values derived from plain chunk arithmetic on the request/response words.
module tb_narrow_link_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_req;
  logic [2:0] rx_data;
  logic       rx_ack;
  logic       tx_req;
  logic [2:0] tx_data;
  logic       tx_ack;
  logic       req_valid;
  logic [3:0] req_data;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;

  int checks   = 0;
  int failures = 0;

  narrow_link_responder #(.BW_LINK(3), .BW_REQ(4), .BW_RSP(8)) dut (
    .clk(clk), .rst(rst),
    .rx_req(rx_req), .rx_data(rx_data), .rx_ack(rx_ack),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response chunk i of word r: zero-extended, least significant chunk first
  function automatic logic [2:0] rsp_chunk(input logic [7:0] r, input int i);
    int unsigned z;
    z = 32'(r);
    return 3'((z >> (3 * i)) & 7);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ack"}, 32'(rx_ack), 0);
    check({tag, "_tx_req"}, 32'(tx_req), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_req_valid"}, 32'(req_valid), 0);
    check({tag, "_req_data"}, 32'(req_data), 0);
    check({tag, "_rsp_ready"}, 32'(rsp_ready), 0);
  endtask

  task automatic send_chunk(input logic [2:0] d);
    int n;
    rx_data = d;
    rx_req  = 1'b1;
    n = 0;
    while (!rx_ack && n < 50) begin tick(); n++; end
    check("rx_ack_latency", 32'(n), 3);
    rx_req = 1'b0;
    n = 0;
    while (rx_ack && n < 50) begin tick(); n++; end
    check("rx_ack_fall", 32'(rx_ack), 0);
    rx_data = 3'($urandom);
  endtask

  task automatic do_txn(input logic [3:0] req, input logic [1:0] pad, input logic [7:0] rsp,
                        input int bp, input int ack_dly, input int abort_chunk);
    logic [5:0] full;
    logic [2:0] prev;
    logic [2:0] exp_c;
    int n;
    full = {pad, req};
    for (int i = 0; i < 2; i++) send_chunk(full[i*3 +: 3]);

    n = 0;
    while (!req_valid && n < 50) begin tick(); n++; end
    check("req_valid", 32'(req_valid), 1);
    check("req_data", 32'(req_data), 32'(req));
    check("rsp_ready_in_deliver", 32'(rsp_ready), 0);

    req_ready = 1'b0;
    for (int k = 0; k < bp; k++) begin
      if (bp >= 10) begin
        if (k == 2) rx_req = 1'b1;
        if (k == 6) rx_req = 1'b0;
        if (k == 3) tx_ack = 1'b1;
        if (k == 4) tx_ack = 1'b0;
      end
      tick();
      check("bp_req_valid", 32'(req_valid), 1);
      check("bp_req_data", 32'(req_data), 32'(req));
      check("bp_rsp_ready", 32'(rsp_ready), 0);
      check("bp_rx_ack", 32'(rx_ack), 0);
    end

    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("req_valid_drop", 32'(req_valid), 0);
    check("rsp_ready_rise", 32'(rsp_ready), 1);

    rsp_valid = 1'b1;
    rsp_data  = rsp;
    tick();
    rsp_valid = 1'b0;
    rsp_data  = 8'($urandom);
    check("rsp_ready_drop", 32'(rsp_ready), 0);
    check("tx_req_before_data", 32'(tx_req), 0);

    for (int i = 0; i < 3; i++) begin
      exp_c = rsp_chunk(rsp, i);
      n = 0;
      prev = tx_data;
      while (!tx_req && n < 50) begin prev = tx_data; tick(); n++; end
      check("tx_req_rise", 32'(tx_req), 1);
      check("tx_data_chunk", 32'(tx_data), 32'(exp_c));
      check("tx_data_settled", 32'(prev), 32'(tx_data));
      if (i == abort_chunk) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_reset");
        return;
      end
      for (int k = 0; k < ack_dly; k++) begin
        tick();
        check("slow_ack_tx_req", 32'(tx_req), 1);
        check("slow_ack_tx_data", 32'(tx_data), 32'(exp_c));
      end
      tx_ack = 1'b1;
      n = 0;
      while (tx_req && n < 50) begin tick(); n++; end
      check("tx_req_fall", 32'(tx_req), 0);
      check("tx_data_hold", 32'(tx_data), 32'(exp_c));
      tx_ack = 1'b0;
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    rx_req    = 1'b0;
    rx_data   = '0;
    tx_ack    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    do_txn(4'hD, 2'b00, 8'hA5, 10, 20, -1);
    do_txn(4'($urandom), 2'($urandom), 8'($urandom), 2, 3, 1);
    do_txn(4'($urandom), 2'($urandom), 8'($urandom), 3, 2, -1);
    for (int t = 0; t < 15; t++) begin
      do_txn(4'($urandom), 2'($urandom), 8'($urandom),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
